ram_bist: RTL and testbench

RAM_BIST -- requirements
Module: ram_bist

---
 rtl/ram_bist.sv | 183 ++++++++++++++++++
 tb/tb_ram_bist.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ram_bist.sv
// March-style BIST for a 32x32 synchronous RAM: writes an address-derived pattern, then reads back and compares.
// Optional second pass with the inverted pattern when RAM_BIST_INV_PASS_EN is defined.
module ram_bist (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] seed,
    output logic        ena,
    output logic        wena,
    output logic [4:0]  addr,
    output logic [31:0] data_in,
    input  logic [31:0] data_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [5:0]  err_cnt,
    output logic [4:0]  first_err_addr
);

    // state   | meaning
    // IDLE    | waiting for start, RAM interface quiet
    // WRITE   | one pattern word written per cycle, addr 0..31
    // RD_ADDR | read address presented to the RAM
    // RD_CMP  | RAM read data compared against the expected word
    // DONE    | results held, start restarts the test
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_ADDR = 3'd2,
        RD_CMP  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] seed_q, seed_nxt;
    logic        ena_nxt, wena_nxt, busy_nxt, done_nxt, pass_nxt;
    logic [4:0]  addr_nxt, fea_nxt;
    logic [31:0] data_in_nxt;
    logic [5:0]  err_nxt;
    logic [31:0] exp_word;
    logic [31:0] wr_word_next;
    logic        mismatch;

`ifdef RAM_BIST_INV_PASS_EN
    logic inv, inv_nxt;

    always_comb begin
        exp_word     = (seed_q + {27'd0, addr} + 32'd1) ^ {32{inv}};
        wr_word_next = (seed_q + {27'd0, addr} + 32'd2) ^ {32{inv}};
    end
`else
    always_comb begin
        exp_word     = seed_q + {27'd0, addr} + 32'd1;
        wr_word_next = seed_q + {27'd0, addr} + 32'd2;
    end
`endif

    assign mismatch = (data_out != exp_word);

    always_comb begin
        state_nxt   = state;
        seed_nxt    = seed_q;
        ena_nxt     = ena;
        wena_nxt    = wena;
        addr_nxt    = addr;
        data_in_nxt = data_in;
        busy_nxt    = busy;
        done_nxt    = done;
        pass_nxt    = pass;
        err_nxt     = err_cnt;
        fea_nxt     = first_err_addr;
`ifdef RAM_BIST_INV_PASS_EN
        inv_nxt     = inv;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt   = WRITE;
                    seed_nxt    = seed;
                    ena_nxt     = 1'b1;
                    wena_nxt    = 1'b1;
                    addr_nxt    = 5'd0;
                    data_in_nxt = seed + 32'd1;
                    busy_nxt    = 1'b1;
                    done_nxt    = 1'b0;
                    pass_nxt    = 1'b0;
                    err_nxt     = 6'd0;
                    fea_nxt     = 5'd0;
`ifdef RAM_BIST_INV_PASS_EN
                    inv_nxt     = 1'b0;
`endif
                end
            end
            WRITE: begin
                if (addr == 5'd31) begin
                    state_nxt   = RD_ADDR;
                    wena_nxt    = 1'b0;
                    addr_nxt    = 5'd0;
                    data_in_nxt = 32'd0;
                end else begin
                    addr_nxt    = addr + 5'd1;
                    data_in_nxt = wr_word_next;
                end
            end
            RD_ADDR: begin
                state_nxt = RD_CMP;
            end
            RD_CMP: begin
                if (mismatch) begin
                    err_nxt = (err_cnt == 6'd32) ? 6'd32 : err_cnt + 6'd1;
                    if (err_cnt == 6'd0)
                        fea_nxt = addr;
                end
                if (addr != 5'd31) begin
                    state_nxt = RD_ADDR;
                    addr_nxt  = addr + 5'd1;
`ifdef RAM_BIST_INV_PASS_EN
                end else if (!inv) begin
                    // second pass: rewrite the array with the complemented pattern
                    state_nxt   = WRITE;
                    inv_nxt     = 1'b1;
                    wena_nxt    = 1'b1;
                    addr_nxt    = 5'd0;
                    data_in_nxt = ~(seed_q + 32'd1);
`endif
                end else begin
                    state_nxt   = DONE;
                    ena_nxt     = 1'b0;
                    wena_nxt    = 1'b0;
                    addr_nxt    = 5'd0;
                    data_in_nxt = 32'd0;
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                    pass_nxt    = (err_nxt == 6'd0);
                end
            end
            default: begin
                state_nxt   = IDLE;
                ena_nxt     = 1'b0;
                wena_nxt    = 1'b0;
                addr_nxt    = 5'd0;
                data_in_nxt = 32'd0;
                busy_nxt    = 1'b0;
                done_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            seed_q         <= 32'd0;
            ena            <= 1'b0;
            wena           <= 1'b0;
            addr           <= 5'd0;
            data_in        <= 32'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= 6'd0;
            first_err_addr <= 5'd0;
`ifdef RAM_BIST_INV_PASS_EN
            inv            <= 1'b0;
`endif
        end else begin
            state          <= state_nxt;
            seed_q         <= seed_nxt;
            ena            <= ena_nxt;
            wena           <= wena_nxt;
            addr           <= addr_nxt;
            data_in        <= data_in_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            pass           <= pass_nxt;
            err_cnt        <= err_nxt;
            first_err_addr <= fea_nxt;
`ifdef RAM_BIST_INV_PASS_EN
            inv            <= inv_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist: synchronous RAM model with selectable faults, hand-computed expectations.
module tb_ram_bist;

`ifdef RAM_BIST_INV_PASS_EN
    localparam int LAT = 193;
    localparam bit INV = 1'b1;
`else
    localparam int LAT = 97;
    localparam bit INV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] seed = 32'd0;
    logic        ena, wena, busy, done, pass;
    logic [4:0]  addr, first_err_addr;
    logic [31:0] data_in, data_out;
    logic [5:0]  err_cnt;

    logic [31:0] mem [32];
    logic [31:0] rd_q;
    logic [4:0]  rd_addr_q;
    int          fault = 0;   // 0 good, 1 bit3 stuck-at-1, 2 addr 17 corrupted
    int          wr_count = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    ram_bist dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .ena(ena), .wena(wena), .addr(addr), .data_in(data_in),
        .data_out(data_out), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ena && wena) begin
            mem[addr] <= data_in;
            wr_count  <= wr_count + 1;
        end
        if (ena && !wena) begin
            rd_q      <= mem[addr];
            rd_addr_q <= addr;
        end
    end

    always_comb begin
        data_out = rd_q;
        if (fault == 1)
            data_out = rd_q | 32'h0000_0008;
        else if (fault == 2 && rd_addr_q == 5'd17)
            data_out = rd_q ^ 32'h0000_0100;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [31:0] s);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int first, output int lat);
        lat = first;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    function automatic logic [31:0] pat(input logic [31:0] s, input int a);
        logic [31:0] w;
        w = s + a + 1;
        return INV ? ~w : w;
    endfunction

    initial begin
        int lat;
        int wr_snap;
        int guard;

        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        rd_q = 32'd0;
        rd_addr_q = 5'd0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs", {ena, wena, addr, busy, done, pass, err_cnt, first_err_addr}, 32'd0);
        chk("rst_data_in", data_in, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_start", {ena, wena, busy, done}, 32'd0);

        // good RAM, seed 0
        start_run(32'd0);
        chk("write0_ctl", {ena, wena, busy, addr}, {27'd0, 3'b111, 2'b00} >> 0 == 0 ? 32'd0 : {24'd0, 1'b1, 1'b1, 1'b1, 5'd0});
        chk("write0_data", data_in, 32'd1);
        wait_done(1, lat);
        chk("good_latency", lat, LAT);
        chk("good_pass", {31'd0, pass}, 32'd1);
        chk("good_err_cnt", {26'd0, err_cnt}, 32'd0);
        chk("good_done_ctl", {ena, wena, busy}, 32'd0);
        chk("good_mem0", mem[0], pat(32'd0, 0));
        chk("good_mem31", mem[31], pat(32'd0, 31));

        // data_out bit 3 stuck at 1
        fault = 1;
        start_run(32'd0);
        wait_done(1, lat);
        chk("bit3_err_cnt", {26'd0, err_cnt}, INV ? 32'd32 : 32'd16);
        chk("bit3_first_addr", {27'd0, first_err_addr}, 32'd0);
        chk("bit3_pass", {31'd0, pass}, 32'd0);

        // only addr 17 corrupted, seed wraps at addr 15
        fault = 2;
        start_run(32'hFFFF_FFF0);
        wait_done(1, lat);
        chk("a17_latency", lat, LAT);
        chk("a17_err_cnt", {26'd0, err_cnt}, INV ? 32'd2 : 32'd1);
        chk("a17_first_addr", {27'd0, first_err_addr}, 32'd17);
        chk("a17_pass", {31'd0, pass}, 32'd0);
        chk("a17_mem15_wrap", mem[15], INV ? 32'hFFFF_FFFF : 32'd0);
        chk("a17_mem16", mem[16], INV ? 32'hFFFF_FFFE : 32'd1);

        // reset pulse during write at addr 10
        fault = 0;
        start_run(32'd0);
        guard = 0;
        while (addr != 5'd10 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_addr10", {27'd0, addr}, 32'd10);
        wr_snap = wr_count;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {ena, wena, addr, busy, done, pass, err_cnt, first_err_addr}, 32'd0);
        chk("midrst_data_in", data_in, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_no_write", wr_count, wr_snap);
        chk("midrst_idle", {ena, busy, done}, 32'd0);
        start_run(32'd0);
        wait_done(1, lat);
        chk("postrst_latency", lat, LAT);
        chk("postrst_pass", {31'd0, pass}, 32'd1);

        // start held high 5 extra cycles in WRITE, faulty RAM
        fault = 1;
        @(negedge clk);
        seed  = 32'd0;
        start = 1'b1;
        repeat (6) @(negedge clk);
        start = 1'b0;
        chk("held_addr", {27'd0, addr}, 32'd5);
        chk("held_data_in", data_in, 32'd6);
        chk("held_busy", {31'd0, busy}, 32'd1);
        wait_done(6, lat);
        chk("held_latency", lat, LAT);
        chk("held_err_cnt", {26'd0, err_cnt}, INV ? 32'd32 : 32'd16);

        // restart from DONE with a good RAM
        fault = 0;
        start_run(32'h1234_5678);
        chk("restart_err_clr", {26'd0, err_cnt}, 32'd0);
        chk("restart_ctl", {done, busy, wena, addr}, {24'd0, 1'b0, 1'b1, 1'b1, 5'd0});
        chk("restart_data", data_in, 32'h1234_5679);
        wait_done(1, lat);
        chk("restart_latency", lat, LAT);
        chk("restart_pass", {31'd0, pass}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
